// File: rtl/sam_mouse_pkg.sv
// Shared constants and types for the SAM Coupe mouse nibbler.
package sam_mouse_pkg;

  localparam int ACC_W_DEF          = 12;
  localparam int TIMEOUT_CYCLES_DEF = 600;

  // Read-sequence steps, in the order the CPU sees the nibbles.
  localparam logic [2:0] STEP_SYNC = 3'd0;
  localparam logic [2:0] STEP_BTN  = 3'd1;
  localparam logic [2:0] STEP_Y2   = 3'd2;
  localparam logic [2:0] STEP_Y1   = 3'd3;
  localparam logic [2:0] STEP_Y0   = 3'd4;
  localparam logic [2:0] STEP_X2   = 3'd5;
  localparam logic [2:0] STEP_X1   = 3'd6;
  localparam logic [2:0] STEP_X0   = 3'd7;

  // Bit positions within PS/2 mouse byte 0.
  localparam int B0_LEFT  = 0;
  localparam int B0_RIGHT = 1;
  localparam int B0_MID   = 2;
  localparam int B0_SYNC  = 3;
  localparam int B0_XSIGN = 4;
  localparam int B0_YSIGN = 5;
  localparam int B0_XOVF  = 6;
  localparam int B0_YOVF  = 7;

  typedef struct packed {
    logic mid;
    logic right;
    logic left;
  } buttons_t;

  // Header fields kept from byte 0 until the packet completes.
  typedef struct packed {
    logic     yovf;
    logic     xovf;
    logic     ysign;
    logic     xsign;
    buttons_t btn;
  } hdr_t;

endpackage

// File: rtl/ps2_mouse_packet.sv
// Assembles 3-byte PS/2 mouse packets into buttons and 9-bit signed deltas.
module ps2_mouse_packet
  import sam_mouse_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output buttons_t          buttons_o,
  output logic signed [8:0] dx_o,
  output logic signed [8:0] dy_o,
  output logic              packet_done_o
);

  logic [1:0]        pos_q, pos_d;
  hdr_t              hdr_q, hdr_d;
  logic [7:0]        x_lo_q, x_lo_d;
  buttons_t          buttons_q, buttons_d;
  logic signed [8:0] dx_q, dx_d;
  logic signed [8:0] dy_q, dy_d;
  logic              done_q, done_d;

  // Byte position tracking; a header without the sync bit is dropped.
  always_comb begin
    pos_d     = pos_q;
    hdr_d     = hdr_q;
    x_lo_d    = x_lo_q;
    buttons_d = buttons_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    done_d    = 1'b0;
    if (byte_valid_i) begin
      case (pos_q)
        2'd0: begin
          if (byte_i[B0_SYNC]) begin
            hdr_d.btn.left  = byte_i[B0_LEFT];
            hdr_d.btn.right = byte_i[B0_RIGHT];
            hdr_d.btn.mid   = byte_i[B0_MID];
            hdr_d.xsign     = byte_i[B0_XSIGN];
            hdr_d.ysign     = byte_i[B0_YSIGN];
            hdr_d.xovf      = byte_i[B0_XOVF];
            hdr_d.yovf      = byte_i[B0_YOVF];
            pos_d           = 2'd1;
          end
        end
        2'd1: begin
          x_lo_d = byte_i;
          pos_d  = 2'd2;
        end
        default: begin
          buttons_d = hdr_q.btn;
          dx_d      = hdr_q.xovf ? 9'sd0 : {hdr_q.xsign, x_lo_q};
          dy_d      = hdr_q.yovf ? 9'sd0 : {hdr_q.ysign, byte_i};
          done_d    = 1'b1;
          pos_d     = 2'd0;
        end
      endcase
    end
  end

  // Packet state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q     <= 2'd0;
      hdr_q     <= '0;
      x_lo_q    <= 8'd0;
      buttons_q <= '0;
      dx_q      <= 9'sd0;
      dy_q      <= 9'sd0;
      done_q    <= 1'b0;
    end else begin
      pos_q     <= pos_d;
      hdr_q     <= hdr_d;
      x_lo_q    <= x_lo_d;
      buttons_q <= buttons_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      done_q    <= done_d;
    end
  end

  assign buttons_o     = buttons_q;
  assign dx_o          = dx_q;
  assign dy_o          = dy_q;
  assign packet_done_o = done_q;

endmodule

// File: rtl/sam_mouse_nibbler.sv
// SAM Coupe mouse interface: accumulates PS/2 motion and serves it as an
// eight-step nibble sequence on successive CPU reads of the mouse port.
module sam_mouse_nibbler
  import sam_mouse_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int ACC_W          = ACC_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ps2_byte,
  input  logic       ps2_byte_valid,
  input  logic       rdmsel,
  output logic [3:0] mdata,
  output logic [2:0] seq_idx
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  buttons_t          buttons;
  logic signed [8:0] dx, dy;
  logic              packet_done;

  logic                    rdmsel_q;
  logic [2:0]              seq_q, seq_d;
  logic [IDLE_W-1:0]       idle_q, idle_d;
  logic signed [ACC_W-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic signed [ACC_W-1:0] lat_x_q, lat_x_d, lat_y_q, lat_y_d;
  logic [3:0]              mdata_q, mdata_d;
  logic                    rise, fall, snap;
  logic [11:0]             lx, ly;

  function automatic logic signed [ACC_W-1:0] sat_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [8:0]       d
  );
    logic signed [ACC_W:0] s;
    s = (ACC_W+1)'(a) + (ACC_W+1)'(d);
    if (s[ACC_W] != s[ACC_W-1]) return s[ACC_W] ? ACC_MIN : ACC_MAX;
    return s[ACC_W-1:0];
  endfunction

  ps2_mouse_packet u_packet (
    .clk           (clk),
    .rst           (rst),
    .byte_i        (ps2_byte),
    .byte_valid_i  (ps2_byte_valid),
    .buttons_o     (buttons),
    .dx_o          (dx),
    .dy_o          (dy),
    .packet_done_o (packet_done)
  );

  // Read sequencing, idle timeout, accumulate/snapshot and nibble select.
  always_comb begin
    rise = rdmsel & ~rdmsel_q;
    fall = ~rdmsel & rdmsel_q;
    // Snapshot happens as the sequence leaves the button step.
    snap = fall && (seq_q == STEP_BTN);

    seq_d  = seq_q;
    idle_d = idle_q;
    if (rise || fall || rdmsel) begin
      idle_d = '0;
    end else if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
      idle_d = '0;
      seq_d  = STEP_SYNC;
    end else begin
      idle_d = idle_q + 1'b1;
    end
    if (fall) seq_d = seq_q + 3'd1;

    // A delta landing with the snapshot goes to the freshly cleared
    // accumulator; the latch keeps the pre-delta total.
    lat_x_d = snap ? acc_x_q : lat_x_q;
    lat_y_d = snap ? acc_y_q : lat_y_q;
    acc_x_d = snap ? '0 : acc_x_q;
    acc_y_d = snap ? '0 : acc_y_q;
    if (packet_done) begin
      acc_x_d = sat_add(acc_x_d, dx);
      acc_y_d = sat_add(acc_y_d, dy);
    end

    lx = 12'(lat_x_d);
    ly = 12'(lat_y_d);
    case (seq_d)
      STEP_SYNC: mdata_d = 4'hF;
      STEP_BTN:  mdata_d = {1'b1, ~buttons.mid, ~buttons.right, ~buttons.left};
      STEP_Y2:   mdata_d = ly[11:8];
      STEP_Y1:   mdata_d = ly[7:4];
      STEP_Y0:   mdata_d = ly[3:0];
      STEP_X2:   mdata_d = lx[11:8];
      STEP_X1:   mdata_d = lx[7:4];
      default:   mdata_d = lx[3:0];
    endcase
  end

  // Sequencer, accumulator and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdmsel_q <= 1'b0;
      seq_q    <= STEP_SYNC;
      idle_q   <= '0;
      acc_x_q  <= '0;
      acc_y_q  <= '0;
      lat_x_q  <= '0;
      lat_y_q  <= '0;
      mdata_q  <= 4'hF;
    end else begin
      rdmsel_q <= rdmsel;
      seq_q    <= seq_d;
      idle_q   <= idle_d;
      acc_x_q  <= acc_x_d;
      acc_y_q  <= acc_y_d;
      lat_x_q  <= lat_x_d;
      lat_y_q  <= lat_y_d;
      mdata_q  <= mdata_d;
    end
  end

  assign mdata   = mdata_q;
  assign seq_idx = seq_q;

endmodule
